// File: rtl/layer_train_sequencer_pkg.sv
// Shared element types and helpers for the layer training sequencer and its error monitors.
package layer_train_sequencer_pkg;

  typedef logic        [7:0] zero2one_t;
  typedef logic signed [7:0] frac_t;

  localparam int unsigned Z2O_W        = $bits(zero2one_t);
  localparam zero2one_t   ZERO2ONE_MAX = '1;

  // One bit wider than the element so the magnitude never wraps.
  function automatic logic [Z2O_W:0] abs_diff(input zero2one_t a, input zero2one_t b);
    return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
  endfunction

endpackage

// File: rtl/layer_train_sequencer_abs_diff_sum.sv
// Combinational L1 distance between two element vectors.
module abs_diff_sum
  import layer_train_sequencer_pkg::*;
#(
  parameter  int unsigned N     = 38,
  localparam int unsigned SUM_W = Z2O_W + $clog2(N) + 1
) (
  input  zero2one_t [N-1:0]     a,
  input  zero2one_t [N-1:0]     b,
  output logic      [SUM_W-1:0] sum
);

  always_comb begin
    sum = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = sum + SUM_W'(abs_diff(a[k], b[k]));
    end
  end

endmodule

// File: rtl/layer_train_sequencer.sv
// Replays stored (input, target) samples into a learning layer for a number of epochs,
// measuring the per-epoch L1 output error and pulsing learn once per sample.
module layer_train_sequencer
  import layer_train_sequencer_pkg::*;
#(
  parameter int unsigned N_IN   = 16,
  parameter int unsigned N_OUT  = 38,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned SETTLE = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          load_we,
  input  logic [$clog2(DEPTH)-1:0]      load_addr,
  input  zero2one_t [N_IN-1:0]          load_in,
  input  zero2one_t [N_OUT-1:0]         load_expected,
  input  logic [$clog2(DEPTH):0]        n_samples,
  input  logic [15:0]                   epochs,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          layer_valid,
  output logic                          layer_learn,
  output zero2one_t [N_IN-1:0]          layer_in,
  output zero2one_t [N_OUT-1:0]         layer_expected,
  input  zero2one_t [N_OUT-1:0]         layer_out,
  output logic [31:0]                   epoch_err,
  output logic [15:0]                   epoch_cnt
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned SUM_W = Z2O_W + $clog2(N_OUT) + 1;
  localparam int unsigned SW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESENT,
    S_MEASURE,
    S_LEARN,
    S_GAP,
    S_DONE
  } state_t;

  state_t              state;
  logic [AW-1:0]       idx;
  logic [SW-1:0]       settle_cnt;
  logic [AW:0]         ns_r;
  logic [15:0]         ep_r;
  logic [31:0]         acc;
  logic [SUM_W-1:0]    sample_err;
  logic [32:0]         acc_sum;
  logic [31:0]         acc_sat;
  logic [AW:0]         ns_clamped;
  logic                last_sample;

  zero2one_t [N_IN-1:0]  mem_in  [DEPTH];
  zero2one_t [N_OUT-1:0] mem_exp [DEPTH];

  always_ff @(posedge clock) begin
    if (load_we && !busy) begin
      mem_in[load_addr]  <= load_in;
      mem_exp[load_addr] <= load_expected;
    end
  end

  // Read is combinational so a write coinciding with start is seen by the first sample.
  always_comb begin
    layer_in       = '0;
    layer_expected = '0;
    if (layer_valid) begin
      layer_in       = mem_in[idx];
      layer_expected = mem_exp[idx];
    end
  end

  abs_diff_sum #(.N(N_OUT)) u_err (
    .a   (layer_out),
    .b   (layer_expected),
    .sum (sample_err)
  );

  always_comb begin
    acc_sum     = {1'b0, acc} + 33'(sample_err);
    acc_sat     = acc_sum[32] ? '1 : acc_sum[31:0];
    ns_clamped  = (n_samples > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : n_samples;
    last_sample = ({1'b0, idx} == (ns_r - (AW+1)'(1)));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      layer_valid <= 1'b0;
      layer_learn <= 1'b0;
      epoch_err   <= '0;
      epoch_cnt   <= '0;
      acc         <= '0;
      idx         <= '0;
      settle_cnt  <= '0;
      ns_r        <= '0;
      ep_r        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            epoch_cnt  <= '0;
            acc        <= '0;
            idx        <= '0;
            settle_cnt <= '0;
            ns_r       <= ns_clamped;
            ep_r       <= epochs;
            if ((n_samples != '0) && (epochs != '0)) begin
              state       <= S_PRESENT;
              busy        <= 1'b1;
              layer_valid <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_PRESENT: begin
          if (settle_cnt == SW'(SETTLE - 1)) begin
            settle_cnt <= '0;
            state      <= S_MEASURE;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        S_MEASURE: begin
          acc         <= acc_sat;
          layer_learn <= 1'b1;
          state       <= S_LEARN;
        end
        S_LEARN: begin
          layer_learn <= 1'b0;
          layer_valid <= 1'b0;
          state       <= S_GAP;
        end
        S_GAP: begin
          if (last_sample) begin
            epoch_err <= acc;
            acc       <= '0;
            epoch_cnt <= epoch_cnt + 16'd1;
            idx       <= '0;
            if ((epoch_cnt + 16'd1) == ep_r) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state       <= S_PRESENT;
              layer_valid <= 1'b1;
            end
          end else begin
            idx         <= idx + AW'(1);
            state       <= S_PRESENT;
            layer_valid <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_train_sequencer.sv
// Directed bench for layer_train_sequencer with a combinational layer stub.
module tb_layer_train_sequencer;
  import layer_train_sequencer_pkg::*;

  localparam int unsigned N_IN   = 16;
  localparam int unsigned N_OUT  = 38;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned SETTLE = 2;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     load_we;
  logic [2:0]               load_addr;
  zero2one_t [N_IN-1:0]     load_in;
  zero2one_t [N_OUT-1:0]    load_expected;
  logic [3:0]               n_samples;
  logic [15:0]              epochs;
  logic                     start;
  logic                     busy;
  logic                     done;
  logic                     layer_valid;
  logic                     layer_learn;
  zero2one_t [N_IN-1:0]     layer_in;
  zero2one_t [N_OUT-1:0]    layer_expected;
  zero2one_t [N_OUT-1:0]    layer_out;
  logic [31:0]              epoch_err;
  logic [15:0]              epoch_cnt;

  logic [1:0] mode;
  int n_vec = 0;
  int n_err = 0;
  int learn_cnt = 0;
  int bad_learn = 0;
  int valid_cnt = 0;
  int done_cnt  = 0;

  layer_train_sequencer #(
    .N_IN   (N_IN),
    .N_OUT  (N_OUT),
    .DEPTH  (DEPTH),
    .SETTLE (SETTLE)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .load_we        (load_we),
    .load_addr      (load_addr),
    .load_in        (load_in),
    .load_expected  (load_expected),
    .n_samples      (n_samples),
    .epochs         (epochs),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .layer_valid    (layer_valid),
    .layer_learn    (layer_learn),
    .layer_in       (layer_in),
    .layer_expected (layer_expected),
    .layer_out      (layer_out),
    .epoch_err      (epoch_err),
    .epoch_cnt      (epoch_cnt)
  );

  always #5 clock = ~clock;

  // Layer stub: 0 -> all max, 1 -> echo target, other -> all zero.
  always_comb begin
    layer_out = '0;
    case (mode)
      2'd0:    for (int k = 0; k < N_OUT; k++) layer_out[k] = ZERO2ONE_MAX;
      2'd1:    layer_out = layer_expected;
      default: layer_out = '0;
    endcase
  end

  always @(posedge clock) begin
    if (layer_learn) learn_cnt <= learn_cnt + 1;
    if (layer_learn && !layer_valid) bad_learn <= bad_learn + 1;
    if (layer_valid) valid_cnt <= valid_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load(input logic [2:0] addr, input logic [7:0] in_v, input logic [7:0] exp_v);
    load_addr     = addr;
    load_in       = {N_IN{in_v}};
    load_expected = {N_OUT{exp_v}};
    load_we       = 1'b1;
    @(posedge clock); #1;
    load_we       = 1'b0;
  endtask

  // exp_cyc==0 means an immediate done; poke issues a write to entry 0 while busy.
  task automatic run(input string tag, input logic [3:0] ns, input logic [15:0] ep,
                     input int exp_cyc, input logic poke, input logic we_with_start);
    int cyc;
    n_samples = ns;
    epochs    = ep;
    start     = 1'b1;
    load_we   = we_with_start;
    @(posedge clock); #1;
    start   = 1'b0;
    load_we = 1'b0;
    if (exp_cyc == 0) begin
      check({tag, " done"}, done, 1);
      check({tag, " busy"}, busy, 0);
    end else begin
      check({tag, " busy"}, busy, 1);
      cyc = 0;
      while (!done && cyc < exp_cyc + 20) begin
        @(posedge clock); #1;
        cyc++;
        load_we = poke && (cyc == 3);
      end
      load_we = 1'b0;
      check({tag, " cycles"}, cyc, exp_cyc);
      check({tag, " busy at done"}, busy, 0);
    end
    @(posedge clock); #1;
    check({tag, " done pulse"}, done, 0);
  endtask

  initial begin
    int snap_a, snap_b;
    int cyc;
    reset = 1'b1; load_we = 1'b0; load_addr = '0; load_in = '0; load_expected = '0;
    n_samples = '0; epochs = '0; start = 1'b0; mode = 2'd0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst valid", layer_valid, 0);
    check("rst learn", layer_learn, 0);
    check("rst epoch_err", epoch_err, 0);
    check("rst epoch_cnt", epoch_cnt, 0);
    check("rst layer_in", 32'(|layer_in), 0);
    check("rst layer_exp", 32'(|layer_expected), 0);

    // Max outputs against zero targets
    load(3'd0, 8'h11, 8'h00);
    load(3'd1, 8'h22, 8'h00);
    mode = 2'd0;
    snap_a = done_cnt;
    run("t1", 4'd2, 16'd3, 3*2*5, 1'b0, 1'b0);
    check("t1 epoch_cnt", epoch_cnt, 3);
    check("t2 epoch_err", epoch_err, 2*38*255);
    check("t1 done count", done_cnt - snap_a, 1);

    // Perfect layer: zero error, one learn per sample
    mode = 2'd1;
    snap_a = learn_cnt;
    snap_b = bad_learn;
    run("t3", 4'd2, 16'd3, 30, 1'b0, 1'b0);
    check("t3 epoch_err", epoch_err, 0);
    check("t3 learn count", learn_cnt - snap_a, 6);
    check("t3 learn w/o valid", bad_learn - snap_b, 0);

    // Zero-length runs
    snap_a = valid_cnt;
    run("t4a", 4'd0, 16'd3, 0, 1'b0, 1'b0);
    check("t4a epoch_cnt", epoch_cnt, 0);
    run("t4b", 4'd2, 16'd0, 0, 1'b0, 1'b0);
    check("t4b epoch_cnt", epoch_cnt, 0);
    check("t4 valid count", valid_cnt - snap_a, 0);
    check("t4 epoch_err held", epoch_err, 0);

    // Write during busy is dropped
    mode = 2'd2;
    load(3'd0, 8'h01, 8'h10);
    load(3'd1, 8'h02, 8'h20);
    load_addr = 3'd0; load_expected = {N_OUT{8'h80}};
    run("t5", 4'd2, 16'd3, 30, 1'b1, 1'b0);
    check("t5 epoch_err", epoch_err, 38*8'h10 + 38*8'h20);

    // Write coinciding with start is seen by the first sample
    load_addr = 3'd0; load_expected = {N_OUT{8'h31}};
    run("t5b", 4'd1, 16'd1, 5, 1'b0, 1'b1);
    check("t5b epoch_err", epoch_err, 38*8'h31);
    check("t5b epoch_cnt", epoch_cnt, 1);

    // n_samples above DEPTH is clamped
    for (int a = 0; a < DEPTH; a++) load(3'(a), 8'h05, 8'h01);
    run("clamp", 4'd15, 16'd1, 8*5, 1'b0, 1'b0);
    check("clamp epoch_err", epoch_err, 8*38);

    // Reset in LEARN of the second epoch
    mode = 2'd0;
    n_samples = 4'd2; epochs = 16'd3; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 0;
    while (!(layer_learn && epoch_cnt == 16'd1) && cyc < 100) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("t6 reached learn", 32'(cyc < 100), 1);
    snap_a = done_cnt;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("t6 busy", busy, 0);
    check("t6 valid", layer_valid, 0);
    check("t6 learn", layer_learn, 0);
    check("t6 epoch_cnt", epoch_cnt, 0);
    repeat (5) @(posedge clock);
    #1;
    check("t6 no done", done_cnt - snap_a, 0);
    run("t6 restart", 4'd2, 16'd3, 30, 1'b0, 1'b0);
    check("t6 epoch_cnt end", epoch_cnt, 3);
    check("t6 epoch_err", epoch_err, 2*38*(255-1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
